// File: rtl/ch_conf_loader.sv
// Packet-driven channel config loader: A5, chan, 10 payload bytes, XOR checksum -> atomic 80-bit commit + ACK/NAK.
// Commit visible two edges after checksum strobe; response held until i_tx_ready; rx bytes dropped while busy responding.
module ch_conf_loader #(
  parameter int          CH_NO       = 4,
  parameter logic [79:0] CONF_RST    = 80'h0,
  parameter int          TIMEOUT_CYC = 434000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [CH_NO*80-1:0]   o_ch_conf,
  output logic [CH_NO-1:0]      o_conf_upd,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int         TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, CHAN, PAYLOAD, CSUM, COMMIT, RESP} state_t;

  state_t               state_q;
  logic [7:0]           idx_q;
  logic [7:0]           csum_q;
  logic [3:0]           cnt_q;
  logic [79:0]          stage_q;
  logic [TW-1:0]        tmo_q;
  logic [CH_NO*80-1:0]  conf_q;
  logic [CH_NO-1:0]     upd_q;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;
  logic                 err_q;

  logic       in_pkt;
  logic       tmo_hit;
  logic       ch_bad;
  logic [7:0] csum_d;

  assign in_pkt  = (state_q == CHAN) || (state_q == PAYLOAD) || (state_q == CSUM);
  // Abort on the TIMEOUT_CYC-th consecutive idle clock since the last byte.
  assign tmo_hit = in_pkt && !i_rx_valid && (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign ch_bad  = int'(i_rx_data) >= CH_NO;
  assign csum_d  = csum_q ^ i_rx_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      stage_q    <= '0;
      tmo_q      <= '0;
      conf_q     <= {CH_NO{CONF_RST}};
      upd_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      upd_q <= '0;
      err_q <= 1'b0;

      if (in_pkt && !i_rx_valid) tmo_q <= tmo_q + TW'(1);
      else                       tmo_q <= '0;

      if (tmo_hit) begin
        state_q <= IDLE;
        stage_q <= '0;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_rx_valid && i_rx_data == HDR) state_q <= CHAN;
          end
          CHAN: begin
            if (i_rx_valid) begin
              idx_q  <= i_rx_data;
              csum_q <= i_rx_data;
              cnt_q  <= '0;
              if (ch_bad) begin
                tx_data_q  <= NAK;
                tx_valid_q <= 1'b1;
                err_q      <= 1'b1;
                state_q    <= RESP;
              end else begin
                state_q <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (i_rx_valid) begin
              stage_q[{cnt_q, 3'b000} +: 8] <= i_rx_data;
              csum_q <= csum_d;
              if (cnt_q == 4'd9) state_q <= CSUM;
              else               cnt_q   <= cnt_q + 4'd1;
            end
          end
          CSUM: begin
            if (i_rx_valid) begin
              if (i_rx_data == csum_q) begin
                state_q <= COMMIT;
              end else begin
                tx_data_q  <= NAK;
                tx_valid_q <= 1'b1;
                err_q      <= 1'b1;
                state_q    <= RESP;
              end
            end
          end
          COMMIT: begin
            // Whole-slice write of the addressed channel only; others keep their value.
            for (int c = 0; c < CH_NO; c++) begin
              if (idx_q == 8'(c)) begin
                conf_q[c*80 +: 80] <= stage_q;
                upd_q[c]           <= 1'b1;
              end
            end
            tx_data_q  <= ACK;
            tx_valid_q <= 1'b1;
            state_q    <= RESP;
          end
          RESP: begin
            if (i_tx_ready) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_ch_conf  = conf_q;
  assign o_conf_upd = upd_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = (state_q != IDLE);
  assign o_err      = err_q;

endmodule
